mrr_loopback_push_ctrl: RTL and testbench

MRR_LOOPBACK_PUSH_CTRL -- requirements
Module: mrr_loopback_push_ctrl

---
 rtl/mrr_loopback_push_ctrl.sv | 135 +++++++++++++
 tb/tb_mrr_loopback_push_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mrr_loopback_push_ctrl.sv
// Staging FIFO plus 4-phase push handshake toward the MRR loopback queue.
// Optional REQ timeout with drop counting is enabled by MRR_LOOPBACK_PUSH_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no request outstanding; waits for a queued message
// LOAD    | copies FIFO head to push_chip_id/push_message and pops it
// REQ     | push_request high; waits for push_ack (or timeout)
// RELEASE | push_request low; waits for push_ack to return low
module mrr_loopback_push_ctrl #(
   parameter int CHIP_ID_LEN          = 8,
   parameter int LOOPBACK_MESSAGE_LEN = 64,
   parameter int FIFO_DEPTH_LOG2      = 2,
   parameter int TIMEOUT_CYCLES       = 1024
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [CHIP_ID_LEN-1:0]          in_chip_id,
   input  logic [LOOPBACK_MESSAGE_LEN-1:0] in_message,
   output logic                            push_request,
   output logic [CHIP_ID_LEN-1:0]          push_chip_id,
   output logic [LOOPBACK_MESSAGE_LEN-1:0] push_message,
   input  logic                            push_ack,
   output logic [FIFO_DEPTH_LOG2:0]        fifo_count,
   output logic [15:0]                     drop_count
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CW    = FIFO_DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      REQ     = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [CHIP_ID_LEN-1:0]          mem_chip [DEPTH];
   logic [LOOPBACK_MESSAGE_LEN-1:0] mem_msg  [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0]      wr_ptr, rd_ptr;
   logic [CW-1:0]                   count;
   logic                            wr_en, pop;
   logic                            tmo_hit;

   assign in_ready     = (count != CW'(DEPTH));
   assign wr_en        = in_valid & in_ready;
   assign pop          = (state == LOAD);
   assign fifo_count   = count;
   assign push_request = (state == REQ);

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_chip[wr_ptr] <= in_chip_id;
         mem_msg[wr_ptr]  <= in_message;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         push_chip_id <= '0;
         push_message <= '0;
      end else if (state == LOAD) begin
         push_chip_id <= mem_chip[rd_ptr];
         push_message <= mem_msg[rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

`ifdef MRR_LOOPBACK_PUSH_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] tmo_cnt;
   logic [15:0] drop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (state == LOAD)     tmo_cnt <= '0;
         else if (state == REQ) tmo_cnt <= tmo_cnt + 1'b1;
         if (tmo_hit && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end
   end

   assign drop_count = drop_cnt;
`else
   assign drop_count = '0;
`endif

   always_comb begin
      state_nxt = state;
      tmo_hit   = 1'b0;
      case (state)
         IDLE:    if (count != '0) state_nxt = LOAD;
         LOAD:    state_nxt = REQ;
         REQ: begin
            if (push_ack) state_nxt = RELEASE;
`ifdef MRR_LOOPBACK_PUSH_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST) begin
               state_nxt = IDLE;
               tmo_hit   = 1'b1;
            end
`endif
         end
         RELEASE: if (!push_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mrr_loopback_push_ctrl.sv
// Directed bench for mrr_loopback_push_ctrl with a payload scoreboard queue.
// Build with MRR_LOOPBACK_PUSH_TIMEOUT_EN to exercise the timeout path (TIMEOUT_CYCLES=16).
module tb_mrr_loopback_push_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_chip_id;
   logic [63:0] in_message;
   logic        push_request;
   logic [7:0]  push_chip_id;
   logic [63:0] push_message;
   logic        push_ack;
   logic [2:0]  fifo_count;
   logic [15:0] drop_count;

   int n_cmp = 0;
   int n_err = 0;
   logic [71:0] sb[$];

`ifdef MRR_LOOPBACK_PUSH_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 1024;
`endif

   mrr_loopback_push_ctrl #(
      .CHIP_ID_LEN(8),
      .LOOPBACK_MESSAGE_LEN(64),
      .FIFO_DEPTH_LOG2(2),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_chip_id(in_chip_id),
      .in_message(in_message),
      .push_request(push_request),
      .push_chip_id(push_chip_id),
      .push_message(push_message),
      .push_ack(push_ack),
      .fifo_count(fifo_count),
      .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns one negedge later with the write done.
   task automatic send(input logic [7:0] c, input logic [63:0] m, output bit acc);
      in_valid   = 1'b1;
      in_chip_id = c;
      in_message = m;
      acc        = in_ready;
      @(negedge clk);
      if (acc) sb.push_back({c, m});
      in_valid = 1'b0;
   endtask

   task automatic wait_req();
      int t;
      t = 0;
      while (push_request !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("req_seen", push_request, 1'b1);
   endtask

   task automatic handshake(input int dly);
      int bad;
      logic [71:0] exp;
      wait_req();
      if (push_request !== 1'b1) return;
      check("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() == 0) return;
      exp = sb.pop_front();
      check("push_data", {push_chip_id, push_message}, exp);
      bad = 0;
      repeat (dly) begin
         @(negedge clk);
         if (push_request !== 1'b1 || {push_chip_id, push_message} !== exp) bad++;
      end
      check("req_hold", bad, 0);
      push_ack = 1'b1;
      @(negedge clk);
      check("req_drop", push_request, 1'b0);
      push_ack = 1'b0;
   endtask

   initial begin
      bit acc;
      int n;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_chip_id = '0;
      in_message = '0;
      push_ack   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req", push_request, 1'b0);
      check("rst_cnt", fifo_count, 3'd0);
      check("rst_rdy", in_ready, 1'b1);
      check("rst_drop", drop_count, 16'd0);
      check("rst_data", {push_chip_id, push_message}, 72'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // single message, ack after 3 cycles
      send(8'h05, 64'hDEADBEEF_00000001, acc);
      check("s1_acc", acc, 1'b1);
      handshake(3);
      repeat (3) @(negedge clk);
      check("s1_cnt", fifo_count, 3'd0);
      check("s1_req", push_request, 1'b0);

      // back-to-back fill with no acks
      for (int i = 0; i < 5; i++) begin
         send(8'h10 + 8'(i), {32'hA5A5_0000, 32'(i)}, acc);
         check("fill_acc", acc, 1'b1);
         if (i == 3) begin
            check("fill4_cnt", fifo_count, 3'd3);
            check("fill4_rdy", in_ready, 1'b1);
         end
      end
      check("full_rdy", in_ready, 1'b0);
      check("full_cnt", fifo_count, 3'd4);
      send(8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, acc);
      check("full_rej", acc, 1'b0);
      check("full_cnt2", fifo_count, 3'd4);
      repeat (5) handshake(1);
      repeat (4) @(negedge clk);
      check("fill_drain", fifo_count, 3'd0);
      check("fill_sb", sb.size(), 0);

      // write coincident with LOAD pop at count 2
      send(8'h21, 64'h2100, acc);
      send(8'h22, 64'h2200, acc);
      send(8'h23, 64'h2300, acc);
      handshake(2);
      @(negedge clk);
      @(negedge clk);
      check("sim_pre", fifo_count, 3'd2);
      send(8'h24, 64'h2400, acc);
      check("sim_acc", acc, 1'b1);
      check("sim_post", fifo_count, 3'd2);
      repeat (3) handshake(0);
      repeat (4) @(negedge clk);
      check("sim_sb", sb.size(), 0);

      // reset during REQ with 3 entries queued
      send(8'h31, 64'h3100, acc);
      wait_req();
      send(8'h32, 64'h3200, acc);
      send(8'h33, 64'h3300, acc);
      send(8'h34, 64'h3400, acc);
      check("mid_cnt", fifo_count, 3'd3);
      check("mid_req", push_request, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req", push_request, 1'b0);
      check("arst_cnt", fifo_count, 3'd0);
      check("arst_rdy", in_ready, 1'b1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (push_request !== 1'b0) n++;
      end
      check("arst_quiet", n, 0);
      check("arst_data", {push_chip_id, push_message}, 72'd0);

`ifdef MRR_LOOPBACK_PUSH_TIMEOUT_EN
      send(8'h41, 64'h4100, acc);
      wait_req();
      n = 0;
      while (push_request === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("tmo_len", n, TMO);
      check("tmo_drop", drop_count, 16'd1);
      if (sb.size() != 0) void'(sb.pop_front());
      send(8'h42, 64'h4200, acc);
      handshake(2);
      check("tmo_drop2", drop_count, 16'd1);
`else
      send(8'h41, 64'h4100, acc);
      handshake(5000);
      check("long_drop", drop_count, 16'd0);
`endif
      repeat (4) @(negedge clk);
      check("end_cnt", fifo_count, 3'd0);
      check("end_sb", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
